segment_address_unit: RTL and testbench

Parametrised segmented address generator between the control unit and the RAM port. Selects a segment (code, data, stack, extra) from the fetch flag, the decoded opcode or an explicit override. Adds the segment base to the offset and checks the offset against a per-segment limit. Owns the stack pointer for PUSH/POP and delivers each physical address through a one-entry registered valid/ready output stage.

---
 rtl/segment_address_unit_pkg.sv | 48 ++++
 rtl/segment_address_unit_descriptor_file.sv | 40 ++++
 rtl/segment_address_unit.sv | 153 +++++++++++++++
 tb/tb_segment_address_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/segment_address_unit_pkg.sv
// Shared constants for the segmented address unit: RAM widths, opcodes,
// segment prefixes/indices, fault codes and the output-stage FSM states.
package segment_address_unit_pkg;

  // RAM geometry
  localparam int addressLegth      = 16;
  localparam int instructionLength = 16;

  // Opcodes live in the top nibble of IR
  localparam int         OPCODE_WIDTH = 4;
  localparam logic [3:0] OP_GETDATA   = 4'h1;
  localparam logic [3:0] OP_SETDATA   = 4'h2;
  localparam logic [3:0] OP_PUSH      = 4'h3;
  localparam logic [3:0] OP_POP       = 4'h4;

  // Segment prefixes (top two physical address bits) and indices
  localparam logic [1:0] PREFIX_CS = 2'b00;
  localparam logic [1:0] PREFIX_DS = 2'b01;
  localparam logic [1:0] PREFIX_SS = 2'b10;
  localparam logic [1:0] PREFIX_ES = 2'b11;

  localparam int SEG_CS = 0;
  localparam int SEG_DS = 1;
  localparam int SEG_SS = 2;
  localparam int SEG_ES = 3;

  typedef enum logic [1:0] {
    FAULT_NONE      = 2'd0,
    FAULT_LIMIT     = 2'd1,
    FAULT_OVERFLOW  = 2'd2,
    FAULT_UNDERFLOW = 2'd3   // also used for an illegal opcode, told apart by segment
  } fault_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic [1:0] seg_prefix(input int idx);
    case (idx % 4)
      SEG_CS:  seg_prefix = PREFIX_CS;
      SEG_DS:  seg_prefix = PREFIX_DS;
      SEG_SS:  seg_prefix = PREFIX_SS;
      default: seg_prefix = PREFIX_ES;
    endcase
  endfunction

endpackage

// File: rtl/segment_address_unit_descriptor_file.sv
// Segment base/limit registers: one write port, one combinational read port.
// Latency: a write is visible to the read port from the following cycle.
module segment_descriptor_file
  import segment_address_unit_pkg::*;
#(
  parameter int ADDR_WIDTH   = addressLegth,
  parameter int OFFSET_WIDTH = addressLegth - 2,
  parameter int SEG_COUNT    = 4,
  localparam int SEG_W       = $clog2(SEG_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [SEG_W-1:0]        wr_idx,
  input  logic [ADDR_WIDTH-1:0]   wr_base,
  input  logic [OFFSET_WIDTH-1:0] wr_limit,
  input  logic [SEG_W-1:0]        rd_idx,
  output logic [ADDR_WIDTH-1:0]   rd_base,
  output logic [OFFSET_WIDTH-1:0] rd_limit
);

  logic [ADDR_WIDTH-1:0]   base_q  [SEG_COUNT];
  logic [OFFSET_WIDTH-1:0] limit_q [SEG_COUNT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SEG_COUNT; i++) begin
        base_q[i]  <= {seg_prefix(i), {(ADDR_WIDTH-2){1'b0}}};
        limit_q[i] <= '1;
      end
    end else if (wr_en) begin
      base_q[wr_idx]  <= wr_base;
      limit_q[wr_idx] <= wr_limit;
    end
  end

  assign rd_base  = base_q[rd_idx];
  assign rd_limit = limit_q[rd_idx];

endmodule

// File: rtl/segment_address_unit.sv
// Segment select, base+offset, limit/stack checks and SP ownership.
// Latency 1 cycle (registered output); while holding, req_ready follows out_ready.
module segment_address_unit
  import segment_address_unit_pkg::*;
#(
  parameter int                          ADDR_WIDTH   = addressLegth,
  parameter int                          OFFSET_WIDTH = addressLegth - 2,
  parameter int                          INSTR_WIDTH  = instructionLength,
  parameter int                          SEG_COUNT    = 4,
  parameter logic [OFFSET_WIDTH-1:0]     STACK_TOP    = '1,
  localparam int                         SEG_W        = $clog2(SEG_COUNT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [INSTR_WIDTH-1:0]  IR,
  input  logic [OFFSET_WIDTH-1:0] in_ADDR,
  input  logic                    select_code_segment,
  input  logic                    seg_override_en,
  input  logic [SEG_W-1:0]        seg_override_idx,
  input  logic                    seg_wr_en,
  input  logic [SEG_W-1:0]        seg_wr_idx,
  input  logic [ADDR_WIDTH-1:0]   seg_wr_base,
  input  logic [OFFSET_WIDTH-1:0] seg_wr_limit,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_WIDTH-1:0]   out_ADDR,
  output logic                    out_fault,
  output logic [1:0]              out_fault_code,
  output logic [SEG_W-1:0]        out_seg,
  output logic [OFFSET_WIDTH-1:0] sp
);

  state_t                  state_q, state_nxt;
  logic                    accept;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    unused_ir_bits;
  logic                    is_push, is_pop, is_data;
  logic                    stack_op, illegal;
  logic [SEG_W-1:0]        sel_seg;
  logic [OFFSET_WIDTH-1:0] offset;
  logic [ADDR_WIDTH-1:0]   seg_base, phys_addr;
  logic [OFFSET_WIDTH-1:0] seg_limit;
  fault_t                  fault;
  logic                    sp_commit;

  assign opcode         = IR[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign unused_ir_bits = ^IR[INSTR_WIDTH-OPCODE_WIDTH-1:0];
  assign is_push        = (opcode == OP_PUSH);
  assign is_pop         = (opcode == OP_POP);
  assign is_data        = (opcode == OP_GETDATA) || (opcode == OP_SETDATA);

  // Fetch and explicit override are plain memory accesses; only the
  // opcode-decoded PUSH/POP path touches the stack pointer.
  always_comb begin
    sel_seg  = SEG_W'(SEG_ES);
    stack_op = 1'b0;
    illegal  = 1'b0;
    if (select_code_segment) begin
      sel_seg = SEG_W'(SEG_CS);
    end else if (seg_override_en) begin
      sel_seg = seg_override_idx;
    end else if (is_data) begin
      sel_seg = SEG_W'(SEG_DS);
    end else if (is_push || is_pop) begin
      sel_seg  = SEG_W'(SEG_SS);
      stack_op = 1'b1;
    end else begin
      illegal = 1'b1;
    end
  end

  segment_descriptor_file #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .SEG_COUNT    (SEG_COUNT)
  ) u_desc (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (seg_wr_en),
    .wr_idx   (seg_wr_idx),
    .wr_base  (seg_wr_base),
    .wr_limit (seg_wr_limit),
    .rd_idx   (sel_seg),
    .rd_base  (seg_base),
    .rd_limit (seg_limit)
  );

  always_comb begin
    offset = in_ADDR;
    if (stack_op) begin
      offset = is_push ? (sp - OFFSET_WIDTH'(1)) : sp;
    end
  end

  assign phys_addr = seg_base + ADDR_WIDTH'(offset);

  always_comb begin
    fault = FAULT_NONE;
    if (illegal) begin
      fault = FAULT_UNDERFLOW;
    end else if (stack_op && is_push && (sp == '0)) begin
      fault = FAULT_OVERFLOW;
    end else if (stack_op && is_pop && (sp == STACK_TOP)) begin
      fault = FAULT_UNDERFLOW;
    end else if (offset > seg_limit) begin
      fault = FAULT_LIMIT;
    end
  end

  assign sp_commit = accept && stack_op && (fault == FAULT_NONE);

  always_comb begin
    state_nxt = state_q;
    req_ready = 1'b1;
    case (state_q)
      ST_EMPTY: begin
        if (req_valid) state_nxt = ST_FULL;
      end
      ST_FULL: begin
        req_ready = out_ready;
        if (out_ready && !req_valid) state_nxt = ST_EMPTY;
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  assign accept    = req_valid && req_ready;
  assign out_valid = (state_q == ST_FULL);
  assign out_fault = (out_fault_code != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_EMPTY;
      out_ADDR       <= '0;
      out_fault_code <= 2'd0;
      out_seg        <= '0;
      sp             <= STACK_TOP;
    end else begin
      state_q <= state_nxt;
      if (accept) begin
        out_ADDR       <= illegal ? '0 : phys_addr;
        out_fault_code <= fault;
        out_seg        <= sel_seg;
      end
      if (sp_commit) begin
        sp <= is_push ? (sp - OFFSET_WIDTH'(1)) : (sp + OFFSET_WIDTH'(1));
      end
    end
  end

endmodule

// File: tb/tb_segment_address_unit.sv
// Directed bench for segment_address_unit: default instance plus a STACK_TOP=2 instance.
module tb_segment_address_unit;

  localparam logic [15:0] IR_GET  = 16'h1000;
  localparam logic [15:0] IR_PUSH = 16'h3000;
  localparam logic [15:0] IR_POP  = 16'h4000;
  localparam logic [15:0] IR_BAD  = 16'hF000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [15:0] IR;
  logic [13:0] in_ADDR;
  logic        select_code_segment;
  logic        seg_override_en;
  logic [1:0]  seg_override_idx;
  logic        seg_wr_en;
  logic [1:0]  seg_wr_idx;
  logic [15:0] seg_wr_base;
  logic [13:0] seg_wr_limit;
  logic        out_ready;

  logic        req_ready, out_valid, out_fault;
  logic [15:0] out_ADDR;
  logic [1:0]  out_fault_code, out_seg;
  logic [13:0] sp;

  logic        b_req_ready, b_out_valid, b_out_fault;
  logic [15:0] b_out_ADDR;
  logic [1:0]  b_out_fault_code, b_out_seg;
  logic [13:0] b_sp;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  segment_address_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .IR(IR),
    .in_ADDR(in_ADDR), .select_code_segment(select_code_segment),
    .seg_override_en(seg_override_en), .seg_override_idx(seg_override_idx),
    .seg_wr_en(seg_wr_en), .seg_wr_idx(seg_wr_idx), .seg_wr_base(seg_wr_base),
    .seg_wr_limit(seg_wr_limit), .out_valid(out_valid), .out_ready(out_ready),
    .out_ADDR(out_ADDR), .out_fault(out_fault), .out_fault_code(out_fault_code),
    .out_seg(out_seg), .sp(sp)
  );

  segment_address_unit #(.STACK_TOP(14'd2)) dut_small (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready), .IR(IR),
    .in_ADDR(in_ADDR), .select_code_segment(select_code_segment),
    .seg_override_en(seg_override_en), .seg_override_idx(seg_override_idx),
    .seg_wr_en(seg_wr_en), .seg_wr_idx(seg_wr_idx), .seg_wr_base(seg_wr_base),
    .seg_wr_limit(seg_wr_limit), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ADDR(b_out_ADDR), .out_fault(b_out_fault), .out_fault_code(b_out_fault_code),
    .out_seg(b_out_seg), .sp(b_sp)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [15:0] ir, input logic [13:0] addr);
    IR        = ir;
    in_ADDR   = addr;
    req_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; IR = '0; in_ADDR = '0;
    select_code_segment = 1'b0; seg_override_en = 1'b0; seg_override_idx = '0;
    seg_wr_en = 1'b0; seg_wr_idx = '0; seg_wr_base = '0; seg_wr_limit = '0;
    out_ready = 1'b1;

    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_sp",        32'(sp),        32'h3FFF);
    check("rst_out_addr",  32'(out_ADDR),  32'h0);
    check("rst_fault",     32'(out_fault), 32'd0);
    check("rst_seg",       32'(out_seg),   32'd0);
    rst = 1'b0;
    tick();

    // instruction fetch forces CS
    select_code_segment = 1'b1;
    req(IR_BAD, 14'h05);
    tick();
    req_valid = 1'b0; select_code_segment = 1'b0;
    check("fetch_valid", 32'(out_valid), 32'd1);
    check("fetch_addr",  32'(out_ADDR),  32'h0005);
    check("fetch_seg",   32'(out_seg),   32'd0);
    check("fetch_fault", 32'(out_fault), 32'd0);
    tick();
    check("fetch_drain", 32'(out_valid), 32'd0);

    // DS descriptor write then limit check
    seg_wr_en = 1'b1; seg_wr_idx = 2'd1; seg_wr_base = 16'h0100; seg_wr_limit = 14'h0F;
    tick();
    seg_wr_en = 1'b0;
    req(IR_GET, 14'h10);
    tick();
    check("lim_code", 32'(out_fault_code), 32'd1);
    check("lim_addr", 32'(out_ADDR),       32'h0110);
    req(IR_GET, 14'h0F);
    tick();
    check("inlim_fault", 32'(out_fault), 32'd0);
    check("inlim_addr",  32'(out_ADDR),  32'h010F);
    check("inlim_seg",   32'(out_seg),   32'd1);

    // PUSH, PUSH, POP, POP, POP back-to-back
    req(IR_PUSH, 14'h0);
    tick();
    check("push1_addr", 32'(out_ADDR), 32'hBFFE);
    check("push1_sp",   32'(sp),       32'h3FFE);
    tick();
    check("push2_addr", 32'(out_ADDR), 32'hBFFD);
    check("push2_sp",   32'(sp),       32'h3FFD);
    IR = IR_POP;
    tick();
    check("pop1_addr", 32'(out_ADDR), 32'hBFFD);
    check("pop1_sp",   32'(sp),       32'h3FFE);
    tick();
    check("pop2_addr",  32'(out_ADDR),  32'hBFFE);
    check("pop2_fault", 32'(out_fault), 32'd0);
    tick();
    check("pop3_code", 32'(out_fault_code), 32'd3);
    check("pop3_seg",  32'(out_seg),        32'd2);
    check("pop3_sp",   32'(sp),             32'h3FFF);

    // illegal opcode
    IR = IR_BAD;
    tick();
    check("ill_code", 32'(out_fault_code), 32'd3);
    check("ill_seg",  32'(out_seg),        32'd3);
    check("ill_addr", 32'(out_ADDR),       32'h0);

    // explicit override to ES
    seg_override_en = 1'b1; seg_override_idx = 2'd3;
    req(IR_GET, 14'h07);
    tick();
    seg_override_en = 1'b0;
    check("ovr_addr", 32'(out_ADDR), 32'hC007);
    check("ovr_seg",  32'(out_seg),  32'd3);
    req_valid = 1'b0;
    tick();

    // backpressure: first PUSH accepted, then held three cycles
    out_ready = 1'b0;
    req(IR_PUSH, 14'h0);
    tick();
    check("bp_first_addr", 32'(out_ADDR), 32'hBFFE);
    check("bp_first_sp",   32'(sp),       32'h3FFE);
    for (int i = 0; i < 3; i++) begin
      check("bp_req_ready", 32'(req_ready), 32'd0);
      tick();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_addr",  32'(out_ADDR),  32'hBFFE);
      check("bp_hold_sp",    32'(sp),        32'h3FFE);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'd1);
    tick();
    check("bp_rel1_addr", 32'(out_ADDR), 32'hBFFD);
    check("bp_rel1_sp",   32'(sp),       32'h3FFD);
    tick();
    check("bp_rel2_addr", 32'(out_ADDR), 32'hBFFC);
    check("bp_rel2_sp",   32'(sp),       32'h3FFC);
    req_valid = 1'b0;
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // same-cycle descriptor write sees the old base
    seg_wr_en = 1'b1; seg_wr_idx = 2'd1; seg_wr_base = 16'h0200; seg_wr_limit = 14'hFF;
    req(IR_GET, 14'h05);
    tick();
    seg_wr_en = 1'b0;
    check("wr_same_addr", 32'(out_ADDR), 32'h0105);
    tick();
    check("wr_next_addr", 32'(out_ADDR), 32'h0205);

    // reset while FULL
    req_valid = 1'b0; out_ready = 1'b0;
    tick();
    check("pre_rst_full", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sp",    32'(sp),        32'h3FFF);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    req(IR_GET, 14'h05);
    tick();
    req_valid = 1'b0;
    check("mid_rst_ds_base", 32'(out_ADDR), 32'h4005);
    tick();

    // STACK_TOP = 2 instance: third PUSH overflows
    req(IR_PUSH, 14'h0);
    tick();
    check("small_push1_addr", 32'(b_out_ADDR), 32'h8001);
    check("small_push1_sp",   32'(b_sp),       32'd1);
    tick();
    check("small_push2_addr", 32'(b_out_ADDR), 32'h8000);
    check("small_push2_sp",   32'(b_sp),       32'd0);
    tick();
    req_valid = 1'b0;
    check("small_push3_code", 32'(b_out_fault_code), 32'd2);
    check("small_push3_sp",   32'(b_sp),             32'd0);
    tick();
    check("small_sp_held", 32'(b_sp),        32'd0);
    check("small_drain",   32'(b_out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
